trolley_system_sensor_in: RTL and testbench
===========================================

Name: trolley_system_sensor_in

Overview:
Avalon-MM slave input port, the read-direction counterpart of the trolley motor output ports. It brings asynchronous trolley sensor lines (track switches, end stops, hall sensors) into the clock domain and exposes the live value to the Nios processor. It also latches edges per bit and raises a maskable level interrupt. It sits on the system interconnect beside the motor output ports.

Parameters:
WIDTH, 4, number of sensor inputs (1..32)
EDGE_TYPE, 0, edge captured: 0 rising, 1 falling, 2 any
DEBOUNCE_CYCLES, 50000, stable cycles required before the filtered value changes (used only with the optional feature; ≥2)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  2  register select
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
in_port  in  WIDTH  raw asynchronous sensor inputs
readdata  out  32  read data, combinational from address (read latency 0)
irq  out  1  level interrupt to CPU

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous, active-low, reset_n. Every flop clears on reset_n low.
- Reset values: irq 0; edge capture 0; irq mask 0; sync and filtered registers 0; readdata reflects zeroed registers.
- Synchroniser: two-flop chain per bit, sync1 then sync2. The filtered value equals sync2 when the feature is off.
- Edge detect:
  - prev holds the filtered value from the previous cycle.
  - Rising edge = filt & ~prev; falling edge = ~filt & prev; any = filt ^ prev.
- Arm counter: edge detection is disabled until 3 cycles after reset_n deasserts, so the sync chain fills first. This prevents a spurious capture when inputs are high at reset.
- Register map, no wait states:
  - addr 0 data: RO, zero-extended filtered value. Writes ignored.
  - addr 1: reserved, reads 0, writes ignored.
  - addr 2 irq mask: RW, bits [WIDTH-1:0]. Upper bits read 0.
  - addr 3 edge capture: read returns the latched bits. Write-1-to-clear per bit; 0 bits unchanged.
- Write strobe: chipselect & ~write_n, sampled on the rising clk edge.
- Capture set: bit is set on a detected edge and stays set until cleared.
- Simultaneous set and clear on the same bit in the same cycle: set wins, bit remains 1.
- Interrupt: irq = |(edge_capture & irq_mask), registered. It asserts 1 cycle after capture or mask update, and deasserts 1 cycle after the clearing write.
- Latency from in_port change to capture bit set is 3 cycles without the feature: 2 sync cycles plus 1 capture cycle. irq follows 1 cycle later.
- Pulses shorter than 1 clock may be missed; no requirement to catch them.
- Reset mid-operation: all state clears immediately and the arm counter restarts.

Optional Feature:
Macro SENSOR_IN_DEBOUNCE_EN.
- Defined:
  - Per-bit counter, width $clog2(DEBOUNCE_CYCLES+1).
  - While sync2 differs from filt, the counter increments. It is cleared whenever they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 with a mismatch still present, filt takes sync2 and the counter clears.
  - Any bounce back to the filt value before that point restarts the count.
  - Latency becomes 2 + DEBOUNCE_CYCLES + 1 cycles to capture.
- Undefined: no counters; filt = sync2.

Decomposition:
- Package trolley_system_pkg:
  - Register address constants: ADDR_DATA=0, ADDR_RSVD=1, ADDR_MASK=2, ADDR_EDGE=3.
  - Edge type constants: EDGE_RISE, EDGE_FALL, EDGE_ANY.
- Sub-module trolley_system_debounce: one bit, DEBOUNCE_CYCLES parameter, clk, reset_n, d_in, d_out. It is instantiated WIDTH times under the macro.

Test Plan:
- Reset value with inputs high: WIDTH=4, in_port=4'hF during reset, release, wait 10 cycles. Required: data read 0xF, edge capture 0x0, irq 0.
- Rising capture: EDGE_TYPE=0, mask=0x1, in_port bit0 0→1. Required: edge capture 0x1 exactly 3 cycles later, irq=1 at 4 cycles; the falling edge on bit0 does not set any bit.
- W1C with concurrent edge: capture=0x3, write 0x1 to addr 3 in the same cycle a new edge on bit0 is captured. Required: capture stays 0x3. A later write of 0x3 with no edge gives 0x0 and irq=0 next cycle.
- Mask gating: capture=0x4 with mask=0x0. Required: irq=0. Write mask=0x4 gives irq=1 one cycle later.
- Reads: reserved addr 1 returns 0x00000000. Upper bits of addr 2 return 0 after writing 0xFFFFFFFF.
- Debounce (SENSOR_IN_DEBOUNCE_EN, DEBOUNCE_CYCLES=8):
  - A 5-cycle high glitch on bit1 produces no data change and no capture.
  - A 12-cycle high on bit1 makes data bit1=1 at cycle 2+8, with capture 1 cycle later.

Source files
------------

// File: rtl/trolley_system_pkg.sv
// Shared constants for the trolley sensor input port: register map and edge-type selectors.
package trolley_system_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/trolley_system_debounce.sv
// Single-bit debouncer: the output follows the input only after it has
// disagreed with the output for DEBOUNCE_CYCLES consecutive cycles.
module trolley_system_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_in,
  output logic d_out
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic             out_reg;

  // Any return to the current output value restarts the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg <= '0;
      out_reg <= 1'b0;
    end else if (d_in == out_reg) begin
      cnt_reg <= '0;
    end else if (cnt_reg == CNT_LAST) begin
      out_reg <= d_in;
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign d_out = out_reg;

endmodule

// File: rtl/trolley_system_sensor_in.sv
// Avalon-MM sensor input port: synchronises trolley sensor lines, latches edges, raises a masked irq.
// Optional per-bit debouncing is enabled by defining SENSOR_IN_DEBOUNCE_EN.
module trolley_system_sensor_in
  import trolley_system_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [1:0] ARM_LAST = 2'd3;

  logic [WIDTH-1:0] sync1_reg, sync2_reg;
  logic [WIDTH-1:0] filt;
  logic [WIDTH-1:0] prev_reg;
  logic [WIDTH-1:0] mask_reg;
  logic [WIDTH-1:0] capture_reg, capture_next;
  logic [WIDTH-1:0] raw_edges, edges, clear_bits;
  logic [1:0]       arm_cnt_reg;
  logic             armed;
  logic             wr_en;
  logic             irq_reg;

  // Only the low WIDTH bits of writedata are meaningful.
  logic unused_wdata;
  assign unused_wdata = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= in_port;
      sync2_reg <= sync1_reg;
    end
  end

`ifdef SENSOR_IN_DEBOUNCE_EN
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_debounce
      trolley_system_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk    (clk),
        .reset_n(reset_n),
        .d_in   (sync2_reg[gi]),
        .d_out  (filt[gi])
      );
    end
  endgenerate
`else
  localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;
  assign filt = sync2_reg;
`endif

  always_comb begin
    raw_edges = filt & ~prev_reg;
    case (EDGE_TYPE)
      EDGE_RISE: raw_edges = filt & ~prev_reg;
      EDGE_FALL: raw_edges = ~filt & prev_reg;
      EDGE_ANY:  raw_edges = filt ^ prev_reg;
      default:   raw_edges = filt & ~prev_reg;
    endcase
  end

  // Hold off edge detection until the sync chain and prev have been loaded.
  assign armed = (arm_cnt_reg == ARM_LAST);
  assign edges = armed ? raw_edges : '0;

  assign wr_en      = chipselect & ~write_n;
  assign clear_bits = (wr_en && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;

  // A new edge overrides a clear on the same bit.
  assign capture_next = (capture_reg & ~clear_bits) | edges;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_reg    <= '0;
      arm_cnt_reg <= '0;
      capture_reg <= '0;
      mask_reg    <= '0;
      irq_reg     <= 1'b0;
    end else begin
      prev_reg    <= filt;
      if (!armed) begin
        arm_cnt_reg <= arm_cnt_reg + 2'd1;
      end
      capture_reg <= capture_next;
      if (wr_en && address == ADDR_MASK) begin
        mask_reg <= writedata[WIDTH-1:0];
      end
      irq_reg     <= |(capture_reg & mask_reg);
    end
  end

  assign irq = irq_reg;

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA: readdata[WIDTH-1:0] = filt;
      ADDR_RSVD: readdata = '0;
      ADDR_MASK: readdata[WIDTH-1:0] = mask_reg;
      ADDR_EDGE: readdata[WIDTH-1:0] = capture_reg;
    endcase
  end

endmodule

// File: tb/tb_trolley_system_sensor_in.sv
// Directed bench for trolley_system_sensor_in: table of register vectors plus hand-written timing sequences.
module tb_trolley_system_sensor_in;
  import trolley_system_pkg::*;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        do_wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  in_val;
    int          ticks;
    logic [31:0] exp_rd;
    logic        exp_irq;
    string       name;
  } vec_t;

  vec_t vecs[12];

  trolley_system_sensor_in #(
    .WIDTH(4),
    .EDGE_TYPE(0),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .in_port   (in_port),
    .readdata  (readdata),
    .irq       (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    d          = readdata;
    chipselect = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    reset_n    = 1'b1;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;

`ifdef SENSOR_IN_DEBOUNCE_EN
    in_port = 4'h0;
    #2 reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    repeat (5) tick();
    do_write(ADDR_MASK, 32'h2);
    // short glitch must be filtered out
    in_port = 4'h2;
    repeat (5) tick();
    in_port = 4'h0;
    repeat (15) tick();
    rd(ADDR_DATA, d); check("glitch_data", d, 32'h0);
    rd(ADDR_EDGE, d); check("glitch_capture", d, 32'h0);
    // long high passes after 2 sync + 8 debounce cycles
    in_port = 4'h2;
    repeat (9) tick();
    rd(ADDR_DATA, d); check("db_data_before", d, 32'h0);
    tick();
    rd(ADDR_DATA, d); check("db_data_at_10", d, 32'h2);
    rd(ADDR_EDGE, d); check("db_capture_at_10", d, 32'h0);
    tick();
    rd(ADDR_EDGE, d); check("db_capture_at_11", d, 32'h2);
    check("db_irq_at_11", 32'(irq), 32'h0);
    tick();
    check("db_irq_at_12", 32'(irq), 32'h1);
`else
    // reset with all inputs high: no spurious capture
    in_port = 4'hF;
    #2 reset_n = 1'b0;
    tick(); tick();
    rd(ADDR_DATA, d); check("reset_data", d, 32'h0);
    rd(ADDR_EDGE, d); check("reset_capture", d, 32'h0);
    check("reset_irq", 32'(irq), 32'h0);
    tick();
    reset_n = 1'b1;
    repeat (10) tick();
    rd(ADDR_DATA, d); check("inhigh_data", d, 32'hF);
    rd(ADDR_EDGE, d); check("inhigh_capture", d, 32'h0);
    check("inhigh_irq", 32'(irq), 32'h0);

    // falling edges are not captured in rising mode
    in_port = 4'h0;
    repeat (5) tick();
    rd(ADDR_EDGE, d); check("fall_all_nocap", d, 32'h0);

    // rising-edge latency: capture at 3 cycles, irq at 4
    do_write(ADDR_MASK, 32'h1);
    in_port = 4'h1;
    tick(); tick();
    rd(ADDR_EDGE, d); check("rise_cap_at_2", d, 32'h0);
    tick();
    rd(ADDR_EDGE, d); check("rise_cap_at_3", d, 32'h1);
    check("rise_irq_at_3", 32'(irq), 32'h0);
    tick();
    check("rise_irq_at_4", 32'(irq), 32'h1);
    do_write(ADDR_EDGE, 32'h1);
    check("clr_irq_lag", 32'(irq), 32'h1);
    tick();
    check("clr_irq_low", 32'(irq), 32'h0);
    in_port = 4'h0;
    repeat (5) tick();
    rd(ADDR_EDGE, d); check("fall_bit0_nocap", d, 32'h0);

    // W1C colliding with a new edge on the same bit: set wins
    in_port = 4'h3;
    repeat (4) tick();
    rd(ADDR_EDGE, d); check("cap_0x3", d, 32'h3);
    in_port = 4'h2;
    repeat (4) tick();
    in_port = 4'h3;
    tick(); tick();
    do_write(ADDR_EDGE, 32'h1);
    rd(ADDR_EDGE, d); check("set_wins", d, 32'h3);
    do_write(ADDR_EDGE, 32'h3);
    rd(ADDR_EDGE, d); check("w1c_all", d, 32'h0);
    check("w1c_irq_lag", 32'(irq), 32'h1);
    tick();
    check("w1c_irq_low", 32'(irq), 32'h0);
    in_port = 4'h0;
    repeat (5) tick();

    // register vectors: mask gating, reserved/upper bits, W1C semantics
    vecs[0]  = '{1'b1, ADDR_MASK, 32'h0,        4'h0, 0, 32'h0, 1'b0, "mask_zero"};
    vecs[1]  = '{1'b0, ADDR_EDGE, 32'h0,        4'h4, 4, 32'h4, 1'b0, "masked_cap"};
    vecs[2]  = '{1'b1, ADDR_MASK, 32'h4,        4'h4, 0, 32'h4, 1'b0, "mask_wr_lag"};
    vecs[3]  = '{1'b0, ADDR_EDGE, 32'h0,        4'h4, 1, 32'h4, 1'b1, "mask_irq"};
    vecs[4]  = '{1'b1, ADDR_RSVD, 32'hFFFFFFFF, 4'h4, 0, 32'h0, 1'b1, "rsvd_read"};
    vecs[5]  = '{1'b1, ADDR_MASK, 32'hFFFFFFFF, 4'h4, 1, 32'hF, 1'b1, "mask_upper"};
    vecs[6]  = '{1'b1, ADDR_DATA, 32'h0,        4'h4, 1, 32'h4, 1'b1, "data_ro"};
    vecs[7]  = '{1'b1, ADDR_EDGE, 32'h0,        4'h4, 1, 32'h4, 1'b1, "w0_keeps"};
    vecs[8]  = '{1'b1, ADDR_EDGE, 32'h4,        4'h4, 0, 32'h0, 1'b1, "w1c_irq_lag2"};
    vecs[9]  = '{1'b0, ADDR_EDGE, 32'h0,        4'h4, 1, 32'h0, 1'b0, "w1c_irq_low2"};
    vecs[10] = '{1'b0, ADDR_EDGE, 32'h0,        4'hC, 4, 32'h8, 1'b1, "bit3_rise"};
    vecs[11] = '{1'b1, ADDR_EDGE, 32'h8,        4'h0, 5, 32'h0, 1'b0, "clr_and_fall"};

    for (int i = 0; i < 12; i++) begin
      in_port = vecs[i].in_val;
      if (vecs[i].do_wr) do_write(vecs[i].addr, vecs[i].wdata);
      repeat (vecs[i].ticks) tick();
      rd(vecs[i].addr, d);
      check({vecs[i].name, "_rd"}, d, vecs[i].exp_rd);
      check({vecs[i].name, "_irq"}, 32'(irq), 32'(vecs[i].exp_irq));
    end

    // write strobe without chipselect is ignored
    address   = ADDR_MASK;
    writedata = 32'h0;
    write_n   = 1'b0;
    tick();
    write_n   = 1'b1;
    rd(ADDR_MASK, d); check("no_cs_write", d, 32'hF);

    // asynchronous reset mid-operation clears everything at once
    in_port = 4'h1;
    repeat (4) tick();
    check("pre_reset_irq", 32'(irq), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check("async_irq", 32'(irq), 32'h0);
    rd(ADDR_EDGE, d); check("async_capture", d, 32'h0);
    rd(ADDR_DATA, d); check("async_data", d, 32'h0);
    in_port = 4'hF;
    tick(); tick();
    reset_n = 1'b1;
    repeat (10) tick();
    rd(ADDR_EDGE, d); check("rearm_capture", d, 32'h0);
    rd(ADDR_DATA, d); check("rearm_data", d, 32'hF);
    rd(ADDR_MASK, d); check("rearm_mask", d, 32'h0);
    check("rearm_irq", 32'(irq), 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
